// File: rtl/countdown_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | countdown_pkg : shared types and constants for the countdown core    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package countdown_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_bcd_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit : one BCD down-counting digit with load and borrow chain   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module bcd_digit
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = bcd_clamp(load_val_i);
        end else if (dec_i && borrow_i) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    // Borrow ripples through every zero digit; out of the top digit it means count==0.
    assign borrow_o = borrow_i && (digit_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/countdown_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | countdown_core : 4-digit BCD countdown timer with multiplexed display |
// | Option         : LEADING_ZERO_BLANK_EN blanks leading zero digits     |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module countdown_core
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic        running,
    output logic        done,
    output logic [3:0]  digit_sel,
    output logic [3:0]  seg_num,
    output logic        seg_en
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] c_SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   presc_q;
    logic [TW-1:0]   presc_d;
    logic [SW-1:0]   scan_q;
    logic [1:0]      idx_q;

    digits_t         w_count;
    logic [15:0]     w_count_flat;
    logic [NUM_DIGITS:0] w_borrow;
    logic            w_count_zero;
    logic            w_count_one;
    logic            w_tick;
    logic            w_dec;
    logic [NUM_DIGITS-1:0] w_en;

    assign w_borrow[0]  = 1'b1;
    assign w_count_flat = w_count;
    assign w_count_zero = w_borrow[NUM_DIGITS];
    assign w_count_one  = (w_count_flat == 16'h0001);
    assign w_dec        = w_tick && !w_count_zero;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .load_i     (load),
                .load_val_i (load_val[4*g +: 4]),
                .dec_i      (w_dec),
                .borrow_i   (w_borrow[g]),
                .digit_o    (w_count[g]),
                .borrow_o   (w_borrow[g+1])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blank
            if (g == 0) begin : g_lsd
                assign w_en[g] = 1'b1;
            end else begin : g_upper
                assign w_en[g] = |w_count_flat[4*NUM_DIGITS-1:4*g];
            end
        end
    endgenerate
`else
    assign w_en = '1;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        w_tick  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pause && start && !w_count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The prescaler still advances on the pause edge so a coinciding wrap is not lost.
                    if (presc_q == c_TICK_LAST) begin
                        presc_d = '0;
                        w_tick  = 1'b1;
                    end else begin
                        presc_d = presc_q + TW'(1);
                    end
                    if (w_tick && w_count_one) begin
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start && !w_count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            running   <= 1'b0;
            done      <= 1'b0;
            digit_sel <= 4'b1110;
            seg_num   <= 4'd0;
            seg_en    <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            if (scan_q == c_SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                scan_q <= scan_q + SW'(1);
            end
            running   <= (state_q == ST_RUN);
            done      <= (state_q == ST_DONE);
            digit_sel <= ~(4'b0001 << idx_q);
            seg_num   <= w_count[idx_q];
            seg_en    <= w_en[idx_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_countdown_core : directed bench for countdown_core                 |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_countdown_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        running;
    logic        done;
    logic [3:0]  digit_sel;
    logic [3:0]  seg_num;
    logic        seg_en;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    countdown_core #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .running   (running),
        .done      (done),
        .digit_sel (digit_sel),
        .seg_num   (seg_num),
        .seg_en    (seg_en)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; the display index follows from it.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] ld;
        logic [15:0] cnt;
        logic [3:0]  en_blank;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pause sampled k edges after the start edge just issued.
    task automatic pause_at(input int k);
        repeat (k - 1) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic read_disp(output logic [15:0] cnt, output logic [3:0] en);
        logic [3:0] seen;
        int k;
        seen = 4'h0;
        cnt = 16'h0;
        en = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (digit_sel)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k >= 0) begin
                cnt[4*k +: 4] = seg_num;
                en[k] = seg_en;
                seen[k] = 1'b1;
            end
        end
        check("scan_all_digits_seen", {28'h0, seen}, 32'hF);
    endtask

    logic [15:0] c;
    logic [3:0]  e;
    logic [3:0]  exp_en;
    logic [15:0] pat;
    int          k;

    initial begin
        tbl[0] = '{16'h00A5, 16'h0095, 4'b0011};
        tbl[1] = '{16'h1234, 16'h1234, 4'b1111};
        tbl[2] = '{16'hFFFF, 16'h9999, 4'b1111};
        tbl[3] = '{16'h0000, 16'h0000, 4'b0001};
        tbl[4] = '{16'h9A0B, 16'h9909, 4'b1111};
        tbl[5] = '{16'h0045, 16'h0045, 4'b0011};
        tbl[6] = '{16'h00F0, 16'h0090, 4'b0011};
        tbl[7] = '{16'h000C, 16'h0009, 4'b0001};
        tbl[8] = '{16'h0300, 16'h0300, 4'b0111};

        // Reset values, sampled while rst is still high.
        repeat (3) @(negedge clk);
        check("rst_running", {31'h0, running}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_digit_sel", {28'h0, digit_sel}, 32'hE);
        check("rst_seg_num", {28'h0, seg_num}, 32'h0);
        check("rst_seg_en", {31'h0, seg_en}, 32'h1);
        rst = 1'b0;

        // start with count 0000 in IDLE is ignored.
        pulse_start();
        repeat (2) @(negedge clk);
        check("idle_zero_start_running", {31'h0, running}, 32'h0);

        // Load / clamp / blanking table.
        for (int i = 0; i < 9; i++) begin
            do_load(tbl[i].ld);
            read_disp(c, e);
`ifdef LEADING_ZERO_BLANK_EN
            exp_en = tbl[i].en_blank;
`else
            exp_en = 4'hF;
`endif
            check($sformatf("tbl%0d_count", i), {16'h0, c}, {16'h0, tbl[i].cnt});
            check($sformatf("tbl%0d_seg_en", i), {28'h0, e}, {28'h0, exp_en});
        end

        // Scan order and timing against the edge counter.
        do_load(16'h1234);
        pat = 16'h1234;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k = (cyc == 0) ? 0 : ((cyc - 1) / 2) % 4;
            check("scan_digit_sel", {28'h0, digit_sel}, {28'h0, ~(4'b0001 << k)});
            check("scan_seg_num", {28'h0, seg_num}, {28'h0, pat[4*k +: 4]});
        end

        // Tick timing: no decrement 3 edges after start, one on the 4th (coinciding with pause).
        do_load(16'h0012);
        pulse_start();
        pause_at(3);
        read_disp(c, e);
        check("pause_before_tick_count", {16'h0, c}, 32'h0012);
        check("paused_running", {31'h0, running}, 32'h0);
        pulse_start();
        pause_at(1);
        read_disp(c, e);
        check("tick_with_pause_count", {16'h0, c}, 32'h0011);

        // Twelve cycles from start give 0009.
        do_load(16'h0012);
        pulse_start();
        pause_at(12);
        read_disp(c, e);
        check("twelve_cycle_count", {16'h0, c}, 32'h0009);

        // Uninterrupted run: zero reached 48 edges after start, outputs one edge later.
        do_load(16'h0012);
        pulse_start();
        repeat (48) @(negedge clk);
        check("run_running_before_done", {31'h0, running}, 32'h1);
        check("run_done_latency", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("done_flag", {31'h0, done}, 32'h1);
        check("done_running", {31'h0, running}, 32'h0);
        read_disp(c, e);
        check("done_count", {16'h0, c}, 32'h0000);

        // DONE ignores start and pause.
        pulse_start();
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        repeat (2) @(negedge clk);
        check("done_sticky", {31'h0, done}, 32'h1);
        check("done_sticky_running", {31'h0, running}, 32'h0);

        // load and start together: load wins, IDLE with count 0030.
        @(negedge clk);
        load = 1'b1;
        load_val = 16'h0030;
        start = 1'b1;
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("load_start_done", {31'h0, done}, 32'h0);
        check("load_start_running", {31'h0, running}, 32'h0);
        read_disp(c, e);
        check("load_start_count", {16'h0, c}, 32'h0030);

        // BCD borrow across three digits.
        do_load(16'h1000);
        pulse_start();
        pause_at(4);
        read_disp(c, e);
        check("borrow_count", {16'h0, c}, 32'h0999);

        // Pause 2 cycles after a tick, hold 20 cycles, resume from held prescaler.
        do_load(16'h0005);
        pulse_start();
        pause_at(6);
        repeat (12) @(negedge clk);
        read_disp(c, e);
        check("hold_count", {16'h0, c}, 32'h0004);
        pulse_start();
        pause_at(1);
        read_disp(c, e);
        check("resume_one_edge_count", {16'h0, c}, 32'h0004);
        pulse_start();
        pause_at(1);
        read_disp(c, e);
        check("resume_two_edge_count", {16'h0, c}, 32'h0003);

        // Reset during RUN aborts and clears.
        do_load(16'h0003);
        pulse_start();
        repeat (5) @(negedge clk);
        check("pre_reset_running", {31'h0, running}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_run_running", {31'h0, running}, 32'h0);
        check("reset_run_done", {31'h0, done}, 32'h0);
        read_disp(c, e);
        check("reset_run_count", {16'h0, c}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_core.md
COUNTDOWN_CORE -- requirements
Module: countdown_core

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per countdown decrement (1 s at 50 MHz); legal range >= 2.
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles each display digit is shown; legal range >= 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load  input  1  one-cycle request to load load_val.
REQ-006 load_val  input  16  four BCD digits; [3:0] is the least significant digit.
REQ-007 start  input  1  one-cycle request to start or resume.
REQ-008 pause  input  1  one-cycle request to pause.
REQ-009 running  output  1  high in RUN only.
REQ-010 done  output  1  high in DONE only.
REQ-011 digit_sel  output  4  active-low one-hot digit strobe; bit i selects digit i.
REQ-012 seg_num  output  4  BCD value of the selected digit, for the seven-segment decoder num input.
REQ-013 seg_en  output  1  decoder enable for the selected digit.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSED and DONE.
REQ-015 Priority SHALL be load > pause > start in every state.
REQ-016 load in any state SHALL do all of the following on the next edge: set count to load_val, clear the tick prescaler, enter IDLE.
REQ-017 On load, any load_val digit above 9 SHALL be clamped to 9.
REQ-018 In IDLE or PAUSED, start with count != 0 SHALL enter RUN.
REQ-019 In IDLE, start with count == 0 SHALL be ignored.
REQ-020 In IDLE, pause SHALL be ignored.
REQ-021 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and then wrap; each wrap SHALL decrement count by 1 in BCD with borrow (e.g. 1000 -> 0999).
REQ-022 The decrement that reaches 0000 SHALL enter DONE on the same edge; count SHALL never wrap below 0000.
REQ-023 In RUN, pause SHALL enter PAUSED and the prescaler value SHALL be held.
REQ-024 If a prescaler wrap coincides with pause, the decrement SHALL apply and the FSM SHALL then enter PAUSED.
REQ-025 PAUSED SHALL resume on start from the held prescaler value.
REQ-026 In DONE, start and pause SHALL be ignored; only load or rst leaves DONE.
REQ-027 The scan counter SHALL run freely in all states, advancing the digit index 0 -> 1 -> 2 -> 3 -> 0 every SCAN_DIV cycles.
REQ-028 digit_sel SHALL equal ~(1 << index).
REQ-029 seg_num SHALL equal count digit[index].
REQ-030 All outputs SHALL be registered, with a 1-cycle latency from the state/count change to the output change.

Reset
REQ-031 When rst is high at an edge, the block SHALL clear all state regardless of other inputs: state IDLE, count 0000, both prescalers 0, index 0.
REQ-032 Outputs after reset SHALL be: running=0, done=0, digit_sel=1110, seg_num=0, seg_en=1.
REQ-033 rst asserted during RUN SHALL abort the countdown with no further decrement.

Configuration
REQ-034 With LEADING_ZERO_BLANK_EN defined, seg_en SHALL be 0 for each digit that is zero and above the most significant nonzero digit.
REQ-035 With LEADING_ZERO_BLANK_EN defined, digit 0 SHALL always be enabled.
REQ-036 Without LEADING_ZERO_BLANK_EN, seg_en SHALL be constantly 1.

Structure
REQ-037 Package countdown_pkg SHALL hold the FSM state enum, NUM_DIGITS=4, the BCD_MAX=9 constant and the digit-vector typedef.
REQ-038 Sub-module bcd_digit SHALL implement one BCD digit with load, decrement, borrow-in and borrow-out.
REQ-039 countdown_core SHALL instantiate four bcd_digit instances in a borrow chain.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-040 Countdown: load 0x0012, then start -> count 0011 after 4 cycles; 0009 after 12; 0000 and done=1, running=0 after 48.
REQ-041 Borrow and clamp: load 0x1000, then start -> first tick gives 0999; separately, load 0x00A5 -> count 0095.
REQ-042 Pause: pause 2 cycles after a tick and hold 20 cycles, then start -> next decrement exactly 2 cycles after start, count unchanged while paused.
REQ-043 Simultaneous inputs: in DONE, assert load=0x0030 and start in the same cycle -> IDLE, count 0030, running=0.
REQ-044 Scan: count 0x1234 -> digit_sel 1110/1101/1011/0111 with seg_num 4/3/2/1, each held 2 cycles, then repeating.
REQ-045 Blanking: with LEADING_ZERO_BLANK_EN, count 0045 -> seg_en 0 on digits 3 and 2, 1 on digits 1 and 0; count 0000 -> only digit 0 enabled.
